// File: rtl/ddr3_init_supervisor_if.sv
// Status/LED bundle between the UniPHY DDR3 subsystem, the board LEDs and the init supervisor.
// The master side drives the status inputs and LED source; the slave side is the supervisor.
interface ddr3_init_supervisor_if;
    logic       pll_locked;
    logic       local_init_done;
    logic       local_cal_success;
    logic       local_cal_fail;
    logic [7:0] led_pio;
    logic       sys_reset_n;
    logic       sys_ready;
    logic       init_error;
    logic [3:0] retry_count;
    logic [2:0] state_dbg;
    logic [7:0] led_out;

    modport master (
        output pll_locked, local_init_done, local_cal_success, local_cal_fail, led_pio,
        input  sys_reset_n, sys_ready, init_error, retry_count, state_dbg, led_out
    );

    modport slave (
        input  pll_locked, local_init_done, local_cal_success, local_cal_fail, led_pio,
        output sys_reset_n, sys_ready, init_error, retry_count, state_dbg, led_out
    );
endinterface

// File: rtl/ddr3_init_supervisor.sv
// Holds the Nios II/DDR3 subsystem in reset until UniPHY calibrates, retries or latches failure,
// and owns the board LEDs. Define INIT_SUP_RETRY_EN to allow retries; otherwise errors go to FAIL.
module ddr3_init_supervisor #(
    parameter int unsigned RST_HOLD_CYC    = 16,
    parameter int unsigned CAL_TIMEOUT_CYC = 50_000_000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned BLINK_DIV       = 12_500_000
) (
    input logic                    clk_clk,
    input logic                    reset_reset,
    ddr3_init_supervisor_if.slave  bus
);

`ifdef INIT_SUP_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    localparam int unsigned HoldW  = $clog2(RST_HOLD_CYC + 1);
    localparam int unsigned TimerW = $clog2(CAL_TIMEOUT_CYC + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);
    localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StHold    = 3'd0,
        StWaitCal = 3'd1,
        StReady   = 3'd2,
        StRetry   = 3'd3,
        StFail    = 3'd4
    } state_e;

    state_e              state_q, state_d, err_state;
    logic [3:0]          sync1_q, sync2_q;
    logic                pll_locked_s, init_done_s, cal_success_s, cal_fail_s;
    logic [HoldW-1:0]    hold_cnt_q;
    logic [TimerW-1:0]   timer_q;
    logic [BlinkW-1:0]   blink_cnt_q;
    logic                blink_q;
    logic [3:0]          retry_q;
    logic                retry_ok;
    logic                sys_reset_n_q, sys_ready_q, init_error_q;
    logic [7:0]          led_out_q;

    assign {pll_locked_s, init_done_s, cal_success_s, cal_fail_s} = sync2_q;

    assign retry_ok  = RetryEn && (retry_q < MaxRetry);
    assign err_state = retry_ok ? StRetry : StFail;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldW'(RST_HOLD_CYC - 1)) state_d = StWaitCal;
            end
            StWaitCal: begin
                // Fail outranks success when both arrive together.
                if (cal_fail_s) begin
                    state_d = err_state;
                end else if (pll_locked_s && init_done_s && cal_success_s) begin
                    state_d = StReady;
                end else if (timer_q == TimerW'(CAL_TIMEOUT_CYC - 1)) begin
                    state_d = err_state;
                end
            end
            StReady: begin
                if (!pll_locked_s || cal_fail_s) state_d = err_state;
            end
            StRetry: state_d = StHold;
            StFail:  state_d = StFail;
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= StHold;
            sync1_q       <= '0;
            sync2_q       <= '0;
            hold_cnt_q    <= '0;
            timer_q       <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
            retry_q       <= '0;
            sys_reset_n_q <= 1'b0;
            sys_ready_q   <= 1'b0;
            init_error_q  <= 1'b0;
            led_out_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            sync1_q <= {bus.pll_locked, bus.local_init_done, bus.local_cal_success,
                        bus.local_cal_fail};
            sync2_q <= sync1_q;

            // Counters restart from zero on every entry into their state.
            hold_cnt_q <= (state_q == StHold && state_d == StHold) ? hold_cnt_q + 1'b1 : '0;
            timer_q    <= (state_q == StWaitCal) ? timer_q + 1'b1 : '0;

            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            if (state_d == StRetry && state_q != StRetry && retry_q < MaxRetry) begin
                retry_q <= retry_q + 1'b1;
            end

            // Outputs follow the next state so they line up with state_q.
            sys_reset_n_q <= (state_d == StWaitCal) || (state_d == StReady);
            sys_ready_q   <= (state_d == StReady);
            init_error_q  <= (state_d == StFail);

            unique case (state_q)
                StWaitCal: led_out_q <= {7'b0, blink_q};
                StReady:   led_out_q <= bus.led_pio;
                StFail:    led_out_q <= {8{blink_q}};
                default:   led_out_q <= 8'h00;
            endcase
        end
    end

    assign bus.sys_reset_n = sys_reset_n_q;
    assign bus.sys_ready   = sys_ready_q;
    assign bus.init_error  = init_error_q;
    assign bus.state_dbg   = state_q;
    assign bus.led_out     = led_out_q;

`ifdef INIT_SUP_RETRY_EN
    assign bus.retry_count = retry_q;
`else
    assign bus.retry_count = 4'd0;
`endif

endmodule
